// File: rtl/tone_scan_sequencer.sv
// Time-multiplexes one tone-magnitude detector over four channels, picks the strongest
// present tone, debounces it over sweeps. Optional WAIT timeout: define TONE_SCAN_TIMEOUT_EN.
module tone_scan_sequencer #(
  parameter int MAG_W   = 16,
  parameter int THRESH  = 1000,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  output logic             measStart,
  output logic [1:0]       measChan,
  input  logic             measDone,
  input  logic [MAG_W-1:0] measMag,
  output logic [2:0]       finalAnswer,
  output logic             finalDone,
  output logic             busy,
  output logic             timeoutErr
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, REPORT} state_t;

  localparam logic [MAG_W-1:0] THRESH_M  = MAG_W'(THRESH);
  localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);

  if (CONFIRM < 1 || CONFIRM > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("tone_scan_sequencer: CONFIRM must be 1..15 and TIMEOUT >= 1");
  end

  state_t           state;
  logic [1:0]       chan;
  logic [1:0]       best_ch;
  logic [MAG_W-1:0] best_mag;
  logic [2:0]       last_cand;
  logic [3:0]       confirm_cnt;

  logic [2:0] cand;
  logic [3:0] cnt_next;
  logic       do_report;
  logic       meas_end;
  logic       sweep_end;

  always_comb begin
    cand      = (best_mag >= THRESH_M) ? ({1'b0, best_ch} + 3'd1) : 3'd0;
    cnt_next  = 4'd1;
    if (cand == last_cand)
      cnt_next = (confirm_cnt >= CONFIRM_C) ? CONFIRM_C : (confirm_cnt + 4'd1);
    do_report = (cnt_next == CONFIRM_C) && (cand != finalAnswer);
    sweep_end = ((state == EVAL) && !do_report) || (state == REPORT);
  end

`ifdef TONE_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  // A result arriving on the expiry cycle wins, so timed_out is gated by !measDone.
  assign timed_out = (state == WAIT) && !measDone && (wait_cnt == TW'(TIMEOUT - 1));
  assign meas_end  = measDone || timed_out;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wait_cnt   <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (state != WAIT)  wait_cnt <= '0;
      else if (!measDone) wait_cnt <= wait_cnt + 1'b1;
      if (timed_out)      timeoutErr <= 1'b1;
    end
  end
`else
  assign meas_end   = measDone;
  assign timeoutErr = 1'b0;
`endif

  // NOTE: every output is registered and set on the transition into its state, so
  // measStart/finalDone/finalAnswer line up with the ISSUE/REPORT cycles themselves.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      chan        <= 2'd0;
      best_ch     <= 2'd0;
      best_mag    <= '0;
      last_cand   <= 3'd0;
      confirm_cnt <= 4'd0;
      measStart   <= 1'b0;
      measChan    <= 2'd0;
      finalAnswer <= 3'd0;
      finalDone   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      measStart <= 1'b0;
      finalDone <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= ISSUE;
            chan      <= 2'd0;
            best_mag  <= '0;
            best_ch   <= 2'd0;
            measStart <= 1'b1;
            measChan  <= 2'd0;
            busy      <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (meas_end) begin
            // Strict compare: on a tie the lower channel, measured first, keeps the lead.
            if (measDone && (measMag > best_mag)) begin
              best_mag <= measMag;
              best_ch  <= chan;
            end
            if (chan == 2'd3) begin
              state <= EVAL;
            end else begin
              state     <= ISSUE;
              chan      <= chan + 2'd1;
              measChan  <= chan + 2'd1;
              measStart <= 1'b1;
            end
          end
        end
        EVAL: begin
          last_cand   <= cand;
          confirm_cnt <= cnt_next;
          if (do_report) begin
            state       <= REPORT;
            finalAnswer <= cand;
            finalDone   <= 1'b1;
          end
        end
        REPORT: ;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Shared exit from EVAL (no report) and REPORT: start another sweep or go idle.
      if (sweep_end) begin
        if (enable) begin
          state     <= ISSUE;
          chan      <= 2'd0;
          best_mag  <= '0;
          best_ch   <= 2'd0;
          measStart <= 1'b1;
          measChan  <= 2'd0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule
